// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Request/response bundle for the two data-memory requesters
//                (CPU LSU on port 0, accelerator DMA on port 1) plus the
//                arbiter-to-memory signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
   // Requester port 0
   logic        p0_req;
   logic        p0_we;
   logic [1:0]  p0_size;
   logic [31:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p0_gnt;
   logic        p0_ack;
   logic        p0_err;
   logic [31:0] p0_rdata;
   // Requester port 1
   logic        p1_req;
   logic        p1_we;
   logic [1:0]  p1_size;
   logic [31:0] p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_gnt;
   logic        p1_ack;
   logic        p1_err;
   logic [31:0] p1_rdata;
   // Memory side
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   // Arbiter view
   modport slave (
      input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
      output p0_gnt, p0_ack, p0_err, p0_rdata,
      input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
      output p1_gnt, p1_ack, p1_err, p1_rdata,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   // Requester / memory view
   modport master (
      output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
      input  p0_gnt, p0_ack, p0_err, p0_rdata,
      output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
      input  p1_gnt, p1_ack, p1_err, p1_rdata,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing a 32-bit byte-addressed data
//                memory between two requesters, one transaction in flight.
//                Sub-word stores are performed as atomic read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int MEM_BYTES = 1024
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   dmem_arbiter_if.slave   bus
);

   localparam logic [31:0] C_MAX_ADDR = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_RDW  = 2'd2,
      S_WR   = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_rr_ptr;
   logic        r_id;
   logic        r_we;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_merge;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_err0;
   logic        r_err1;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;

   logic        w_both;
   logic        w_pick;
   logic        w_grant;
   logic        w_sel_we;
   logic [1:0]  w_sel_size;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic        w_sel_in_range;

   // Winner selection: contested requests follow the round-robin pointer.
   // Grant is gated by rst_n so it is low for the whole reset assertion.
   assign w_both         = bus.p0_req & bus.p1_req;
   assign w_pick         = w_both ? r_rr_ptr : bus.p1_req;
   assign w_grant        = (r_state == S_IDLE) & rst_n & (bus.p0_req | bus.p1_req);
   assign w_sel_we       = w_pick ? bus.p1_we    : bus.p0_we;
   assign w_sel_size     = w_pick ? bus.p1_size  : bus.p0_size;
   assign w_sel_addr     = w_pick ? bus.p1_addr  : bus.p0_addr;
   assign w_sel_wdata    = w_pick ? bus.p1_wdata : bus.p0_wdata;
   assign w_sel_in_range = (w_sel_addr <= C_MAX_ADDR);

   assign bus.p0_gnt   = w_grant & ~w_pick;
   assign bus.p1_gnt   = w_grant &  w_pick;
   assign bus.p0_ack   = r_ack0;
   assign bus.p1_ack   = r_ack1;
   assign bus.p0_err   = r_err0;
   assign bus.p1_err   = r_err1;
   assign bus.p0_rdata = r_rdata0;
   assign bus.p1_rdata = r_rdata1;

   // Memory drive: write data only exists in WR; size[1]=0 means a merged sub-word.
   assign bus.mem_addr  = r_addr;
   assign bus.mem_we    = (r_state == S_WR);
   assign bus.mem_wdata = (r_state != S_WR) ? 32'd0 :
                          (r_size[1] ? r_wdata : r_merge);

   // Transaction FSM: arbitration in IDLE, RD/RDW fetch, WR commit, 1-cycle ack pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 1'b0;
         r_id     <= 1'b0;
         r_we     <= 1'b0;
         r_size   <= 2'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_merge  <= 32'd0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rdata0 <= 32'd0;
         r_rdata1 <= 32'd0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_id    <= w_pick;
                  r_we    <= w_sel_we;
                  r_size  <= w_sel_size;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  if (w_both) begin
                     r_rr_ptr <= ~w_pick;
                  end
                  if (!w_sel_in_range) begin
                     // Range error completes without touching memory.
                     if (w_pick) begin
                        r_ack1 <= 1'b1;
                        r_err1 <= 1'b1;
                        if (!w_sel_we) r_rdata1 <= 32'd0;
                     end else begin
                        r_ack0 <= 1'b1;
                        r_err0 <= 1'b1;
                        if (!w_sel_we) r_rdata0 <= 32'd0;
                     end
                     r_state <= S_IDLE;
                  end else if (w_sel_we && w_sel_size[1]) begin
                     r_state <= S_WR;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_state <= S_RDW;
            end
            S_RDW: begin
               if (!r_we) begin
                  if (r_id) begin
                     r_rdata1 <= bus.mem_rdata;
                     r_ack1   <= 1'b1;
                  end else begin
                     r_rdata0 <= bus.mem_rdata;
                     r_ack0   <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end else begin
                  r_merge <= r_size[0] ? {bus.mem_rdata[31:16], r_wdata[15:0]}
                                       : {bus.mem_rdata[31:8],  r_wdata[7:0]};
                  r_state <= S_WR;
               end
            end
            S_WR: begin
               if (r_id) r_ack1 <= 1'b1;
               else      r_ack0 <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                byte-array memory model (registered read, write at edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MEM_BYTES(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: 1024 bytes, little-endian word view, 1-cycle read latency.
   logic [7:0] mem [0:1023];
   logic       mem_clear;
   logic       pl_en;
   logic [9:0] pl_addr;
   logic [7:0] pl_byte;

   // Memory: registered read of the current address, write of all 4 bytes when mem_we.
   always @(posedge clk) begin
      if (bus.mem_addr <= 32'd1020)
         bus.mem_rdata <= {mem[bus.mem_addr[9:0] + 10'd3], mem[bus.mem_addr[9:0] + 10'd2],
                           mem[bus.mem_addr[9:0] + 10'd1], mem[bus.mem_addr[9:0]]};
      else
         bus.mem_rdata <= 32'd0;
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_byte;
      end else if (bus.mem_we && bus.mem_addr <= 32'd1020) begin
         mem[bus.mem_addr[9:0]]         <= bus.mem_wdata[7:0];
         mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
         mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wdata[23:16];
         mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wdata[31:24];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [9:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_byte = d;
      pl_en   = 1'b1;
      @(posedge clk); #1;
      pl_en   = 1'b0;
   endtask

   // One transaction on a port; latency counted in edges after the grant edge.
   task automatic txn(input int port, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rd, output logic err,
                      output int we_cycles, output logic other_ack);
      logic found;
      lat = -1; rd = 32'hxxxx_xxxx; err = 1'bx; we_cycles = 0; other_ack = 1'b0;
      found = 1'b0;
      if (port == 0) begin
         bus.p0_we = we; bus.p0_size = size; bus.p0_addr = addr; bus.p0_wdata = wdata;
         bus.p0_req = 1'b1;
      end else begin
         bus.p1_we = we; bus.p1_size = size; bus.p1_addr = addr; bus.p1_wdata = wdata;
         bus.p1_req = 1'b1;
      end
      #1;
      for (int k = 0; k < 20; k++) begin
         if ((port == 0) ? bus.p0_gnt : bus.p1_gnt) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      if (found) begin
         for (int n = 1; n <= 8; n++) begin
            if (bus.mem_we) we_cycles++;
            if ((port == 0) ? bus.p0_ack : bus.p1_ack) begin
               lat = n;
               rd  = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
               err = (port == 0) ? bus.p0_err : bus.p1_err;
               break;
            end
            if ((port == 0) ? bus.p1_ack : bus.p0_ack) other_ack = 1'b1;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        err;
      int          wec;
      logic        oack;
      logic        found;
      logic [4:0]  seq;
      int          ng, a0, a1;
      logic        dual;
      logic        ack_seen;
      int          we_seen;

      checks = 0; errors = 0;
      rst_n = 1'b0;
      mem_clear = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_byte = '0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_size = 2'd0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_size = 2'd0; bus.p1_addr = '0; bus.p1_wdata = '0;
      @(posedge clk); #1;
      mem_clear = 1'b0;

      // Reset state: request during reset must not be granted
      bus.p0_req = 1'b1;
      #1;
      chk("rst_gnt0", {31'd0, bus.p0_gnt}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_ack", {30'd0, bus.p0_ack, bus.p1_ack}, 32'd0);
      chk("rst_rdata0", bus.p0_rdata, 32'd0);
      bus.p0_req = 1'b0;

      // Memory preloads (memory is independent of the arbiter reset)
      poke(10'd1020, 8'h01); poke(10'd1021, 8'h02); poke(10'd1022, 8'h03); poke(10'd1023, 8'h04);
      poke(10'h030, 8'h5A);
      poke(10'h020, 8'h0D); poke(10'h021, 8'hF0); poke(10'h022, 8'hFE); poke(10'h023, 8'hCA);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: word store then load
      txn(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, lat, rd, err, wec, oack);
      chk("t1_sw_lat", 32'(lat), 32'd2);
      chk("t1_sw_err", {31'd0, err}, 32'd0);
      chk("t1_sw_we", 32'(wec), 32'd1);
      txn(0, 1'b0, 2'b10, 32'h10, 32'h0, lat, rd, err, wec, oack);
      chk("t1_ld_lat", 32'(lat), 32'd3);
      chk("t1_ld_data", rd, 32'hDEADBEEF);
      chk("t1_ld_err", {31'd0, err}, 32'd0);

      // Test 2: byte store on p1 (read-modify-write), then load
      @(posedge clk); #1;
      txn(1, 1'b1, 2'b00, 32'h11, 32'h000000AA, lat, rd, err, wec, oack);
      chk("t2_sb_lat", 32'(lat), 32'd4);
      chk("t2_sb_we", 32'(wec), 32'd1);
      chk("t2_sb_other", {31'd0, oack}, 32'd0);
      txn(1, 1'b0, 2'b10, 32'h10, 32'h0, lat, rd, err, wec, oack);
      chk("t2_ld_data", rd, 32'hDEADAAEF);
      chk("t2_p0_hold", bus.p0_rdata, 32'hDEADBEEF);

      // Test 3: both ports request loads continuously
      @(posedge clk); #1;
      bus.p0_we = 1'b0; bus.p0_size = 2'b10; bus.p0_addr = 32'h10;
      bus.p1_we = 1'b0; bus.p1_size = 2'b10; bus.p1_addr = 32'h30;
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      #1;
      seq = '0; ng = 0; a0 = 0; a1 = 0; dual = 1'b0;
      for (int c = 0; c <= 17; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 13) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; #1; end
         if (bus.p0_ack) a0++;
         if (bus.p1_ack) a1++;
         if (bus.p0_gnt && bus.p1_gnt) dual = 1'b1;
         else if (bus.p0_gnt || bus.p1_gnt) begin
            if (ng < 5) seq[ng] = bus.p1_gnt;
            ng++;
         end
      end
      chk("t3_ngrants", 32'(ng), 32'd5);
      chk("t3_order", {27'd0, seq}, 32'b01010);
      chk("t3_dual", {31'd0, dual}, 32'd0);
      chk("t3_acks0", 32'(a0), 32'd3);
      chk("t3_acks1", 32'(a1), 32'd2);
      chk("t3_p1_data", bus.p1_rdata, 32'h0000005A);

      // Test 4: range boundary
      @(posedge clk); #1;
      txn(0, 1'b0, 2'b10, 32'd1021, 32'h0, lat, rd, err, wec, oack);
      chk("t4_oor_lat", 32'(lat), 32'd1);
      chk("t4_oor_err", {31'd0, err}, 32'd1);
      chk("t4_oor_rdata", rd, 32'd0);
      chk("t4_oor_we", 32'(wec), 32'd0);
      txn(0, 1'b0, 2'b10, 32'd1020, 32'h0, lat, rd, err, wec, oack);
      chk("t4_edge_err", {31'd0, err}, 32'd0);
      chk("t4_edge_data", rd, 32'h04030201);

      // Test 6: unaligned word store, then aligned load
      @(posedge clk); #1;
      txn(0, 1'b1, 2'b11, 32'h31, 32'h11223344, lat, rd, err, wec, oack);
      chk("t6_sw_lat", 32'(lat), 32'd2);
      txn(0, 1'b0, 2'b10, 32'h30, 32'h0, lat, rd, err, wec, oack);
      chk("t6_ld_data", rd, 32'h2233445A);

      // Test 5: half store aborted by reset during RDW
      @(posedge clk); #1;
      bus.p0_we = 1'b1; bus.p0_size = 2'b01; bus.p0_addr = 32'h20; bus.p0_wdata = 32'h1234;
      bus.p0_req = 1'b1;
      #1;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.p0_gnt) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      chk("t5_gnt", {31'd0, found}, 32'd1);
      @(posedge clk); #1;             // RD
      bus.p0_req = 1'b0;
      @(posedge clk); #1;             // RDW
      rst_n = 1'b0;
      #1;
      chk("t5_rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("t5_rst_addr", bus.mem_addr, 32'd0);
      chk("t5_rst_wdata", bus.mem_wdata, 32'd0);
      chk("t5_rst_rdata0", bus.p0_rdata, 32'd0);
      chk("t5_rst_rdata1", bus.p1_rdata, 32'd0);
      ack_seen = 1'b0; we_seen = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) rst_n = 1'b1;
         @(posedge clk); #1;
         if (bus.p0_ack || bus.p1_ack) ack_seen = 1'b1;
         if (bus.mem_we) we_seen++;
      end
      chk("t5_no_ack", {31'd0, ack_seen}, 32'd0);
      chk("t5_no_we", 32'(we_seen), 32'd0);
      chk("t5_mem_word", {mem[10'h023], mem[10'h022], mem[10'h021], mem[10'h020]}, 32'hCAFEF00D);
      bus.p0_we = 1'b0; bus.p0_size = 2'b10; bus.p0_addr = 32'h10;
      bus.p1_we = 1'b0; bus.p1_size = 2'b10; bus.p1_addr = 32'h10;
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      #1;
      chk("t5_first_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'b01);
      @(posedge clk); #1;
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      repeat (4) begin @(posedge clk); #1; end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
